// File: rtl/bfly_pkg.sv
// Shared constants and fixed-point helpers for the radix-2 butterfly and the FFT stage controller.
// Helpers work on a wide signed accumulator type; callers size-cast the result to their own width.
package bfly_pkg;

   localparam int W_DEF    = 8;
   localparam int FRAC_DEF = W_DEF - 1;
   localparam int ACC_W    = 64;

   typedef logic signed [ACC_W-1:0] acc_t;

   // Round half up, then drop frac fractional bits (arithmetic shift keeps the sign).
   function automatic acc_t round_shift(input acc_t x, input int frac);
      acc_t bias;
      bias = (frac > 0) ? (acc_t'(1) <<< (frac - 1)) : '0;
      return (x + bias) >>> frac;
   endfunction

   function automatic acc_t sat_clip(input acc_t x, input int w);
      acc_t hi;
      acc_t lo;
      hi = (acc_t'(1) <<< (w - 1)) - acc_t'(1);
      lo = -(acc_t'(1) <<< (w - 1));
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

   function automatic logic is_sat(input acc_t x, input int w);
      acc_t hi;
      acc_t lo;
      hi = (acc_t'(1) <<< (w - 1)) - acc_t'(1);
      lo = -(acc_t'(1) <<< (w - 1));
      return (x > hi) || (x < lo);
   endfunction

   // Floor division by two when scaling is requested.
   function automatic acc_t scale_half(input acc_t x, input logic sc);
      return sc ? (x >>> 1) : x;
   endfunction

endpackage

// File: rtl/bfly_cmul.sv
// Pipeline stages 1-2 of the butterfly: twiddle conjugate, four partial products, then
// complex combine with rounding. Operand A and the scale flag ride along to stay aligned.
module bfly_cmul
   import bfly_pkg::*;
#(
   parameter int W    = W_DEF,
   parameter int FRAC = W - 1
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_en,
   input  logic                i_valid,
   input  logic                i_inverse,
   input  logic                i_scale,
   input  logic signed [W-1:0] i_a_re,
   input  logic signed [W-1:0] i_a_im,
   input  logic signed [W-1:0] i_b_re,
   input  logic signed [W-1:0] i_b_im,
   input  logic signed [W-1:0] i_w_re,
   input  logic signed [W-1:0] i_w_im,
   output logic                o_valid,
   output logic                o_scale,
   output logic signed [W-1:0] o_a_re,
   output logic signed [W-1:0] o_a_im,
   output logic signed [W+1:0] o_wb_re,
   output logic signed [W+1:0] o_wb_im
);

   localparam int PW = 2 * W + 1;

   // W+1 bits so conjugating the most negative twiddle value stays exact.
   logic signed [W:0]    w_wi_eff;
   logic signed [PW-1:0] w_p_rr;
   logic signed [PW-1:0] w_p_ii;
   logic signed [PW-1:0] w_p_ri;
   logic signed [PW-1:0] w_p_ir;
   logic signed [W+1:0]  w_wb_re;
   logic signed [W+1:0]  w_wb_im;

   logic signed [PW-1:0] r_p_rr;
   logic signed [PW-1:0] r_p_ii;
   logic signed [PW-1:0] r_p_ri;
   logic signed [PW-1:0] r_p_ir;
   logic signed [W-1:0]  r_s1_a_re;
   logic signed [W-1:0]  r_s1_a_im;
   logic                 r_s1_scale;
   logic                 r_s1_valid;

   logic signed [W+1:0]  r_s2_wb_re;
   logic signed [W+1:0]  r_s2_wb_im;
   logic signed [W-1:0]  r_s2_a_re;
   logic signed [W-1:0]  r_s2_a_im;
   logic                 r_s2_scale;
   logic                 r_s2_valid;

   assign w_wi_eff = i_inverse ? -(W + 1)'(i_w_im) : (W + 1)'(i_w_im);

   assign w_p_rr = PW'(i_b_re) * PW'(i_w_re);
   assign w_p_ii = PW'(i_b_im) * PW'(w_wi_eff);
   assign w_p_ri = PW'(i_b_re) * PW'(w_wi_eff);
   assign w_p_ir = PW'(i_b_im) * PW'(i_w_re);

   assign w_wb_re = (W + 2)'(round_shift(acc_t'(r_p_rr) - acc_t'(r_p_ii), FRAC));
   assign w_wb_im = (W + 2)'(round_shift(acc_t'(r_p_ri) + acc_t'(r_p_ir), FRAC));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
      end else if (i_en) begin
         r_s1_valid <= i_valid;
         r_s2_valid <= r_s1_valid;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_en) begin
         r_p_rr     <= w_p_rr;
         r_p_ii     <= w_p_ii;
         r_p_ri     <= w_p_ri;
         r_p_ir     <= w_p_ir;
         r_s1_a_re  <= i_a_re;
         r_s1_a_im  <= i_a_im;
         r_s1_scale <= i_scale;
         r_s2_wb_re <= w_wb_re;
         r_s2_wb_im <= w_wb_im;
         r_s2_a_re  <= r_s1_a_re;
         r_s2_a_im  <= r_s1_a_im;
         r_s2_scale <= r_s1_scale;
      end
   end

   assign o_valid = r_s2_valid;
   assign o_scale = r_s2_scale;
   assign o_a_re  = r_s2_a_re;
   assign o_a_im  = r_s2_a_im;
   assign o_wb_re = r_s2_wb_re;
   assign o_wb_im = r_s2_wb_im;

endmodule

// File: rtl/radix2_butterfly_pipe.sv
// Three-stage radix-2 DIT butterfly X0 = A + W*B, X1 = A - W*B with ready/valid handshake,
// optional halving, output saturation and a sticky overflow flag.
module radix2_butterfly_pipe
   import bfly_pkg::*;
#(
   parameter int W    = W_DEF,
   parameter int FRAC = W - 1
) (
   input  logic                Clock,
   input  logic                nReset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic signed [W-1:0] a_re,
   input  logic signed [W-1:0] a_im,
   input  logic signed [W-1:0] b_re,
   input  logic signed [W-1:0] b_im,
   input  logic signed [W-1:0] w_re,
   input  logic signed [W-1:0] w_im,
   input  logic                inverse,
   input  logic                scale,
   output logic                out_valid,
   input  logic                out_ready,
   output logic signed [W-1:0] x0_re,
   output logic signed [W-1:0] x0_im,
   output logic signed [W-1:0] x1_re,
   output logic signed [W-1:0] x1_im,
   output logic                ovf,
   input  logic                clr_ovf
);

   logic                w_adv;
   logic                w_s2_valid;
   logic                w_s2_scale;
   logic signed [W-1:0] w_s2_a_re;
   logic signed [W-1:0] w_s2_a_im;
   logic signed [W+1:0] w_s2_wb_re;
   logic signed [W+1:0] w_s2_wb_im;
   acc_t                w_pre [4];
   logic signed [W-1:0] w_res [4];
   logic                w_sat_any;

   logic                r_out_valid;
   logic signed [W-1:0] r_x0_re;
   logic signed [W-1:0] r_x0_im;
   logic signed [W-1:0] r_x1_re;
   logic signed [W-1:0] r_x1_im;
   logic                r_ovf;

   // Whole pipe moves as one; it only freezes when the output holds an unaccepted result.
   assign w_adv    = !r_out_valid || out_ready;
   assign in_ready = w_adv;

   bfly_cmul #(
      .W    (W),
      .FRAC (FRAC)
   ) u_cmul (
      .i_clk     (Clock),
      .i_rst_n   (nReset),
      .i_en      (w_adv),
      .i_valid   (in_valid),
      .i_inverse (inverse),
      .i_scale   (scale),
      .i_a_re    (a_re),
      .i_a_im    (a_im),
      .i_b_re    (b_re),
      .i_b_im    (b_im),
      .i_w_re    (w_re),
      .i_w_im    (w_im),
      .o_valid   (w_s2_valid),
      .o_scale   (w_s2_scale),
      .o_a_re    (w_s2_a_re),
      .o_a_im    (w_s2_a_im),
      .o_wb_re   (w_s2_wb_re),
      .o_wb_im   (w_s2_wb_im)
   );

   always_comb begin
      w_pre[0]  = scale_half(acc_t'(w_s2_a_re) + acc_t'(w_s2_wb_re), w_s2_scale);
      w_pre[1]  = scale_half(acc_t'(w_s2_a_im) + acc_t'(w_s2_wb_im), w_s2_scale);
      w_pre[2]  = scale_half(acc_t'(w_s2_a_re) - acc_t'(w_s2_wb_re), w_s2_scale);
      w_pre[3]  = scale_half(acc_t'(w_s2_a_im) - acc_t'(w_s2_wb_im), w_s2_scale);
      w_sat_any = 1'b0;
      for (int i = 0; i < 4; i++) begin
         w_res[i]  = W'(sat_clip(w_pre[i], W));
         w_sat_any = w_sat_any | is_sat(w_pre[i], W);
      end
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_out_valid <= 1'b0;
         r_x0_re     <= '0;
         r_x0_im     <= '0;
         r_x1_re     <= '0;
         r_x1_im     <= '0;
         r_ovf       <= 1'b0;
      end else begin
         if (w_adv) begin
            r_out_valid <= w_s2_valid;
            if (w_s2_valid) begin
               r_x0_re <= w_res[0];
               r_x0_im <= w_res[1];
               r_x1_re <= w_res[2];
               r_x1_im <= w_res[3];
            end
         end
         // A fresh saturation overrides a simultaneous clear.
         r_ovf <= (r_ovf && !clr_ovf) || (w_adv && w_s2_valid && w_sat_any);
      end
   end

   assign out_valid = r_out_valid;
   assign x0_re     = r_x0_re;
   assign x0_im     = r_x0_im;
   assign x1_re     = r_x1_re;
   assign x1_im     = r_x1_im;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_radix2_butterfly_pipe.sv
// Directed, table-driven bench for radix2_butterfly_pipe (W=8, FRAC=7) with hand-computed results.
module tb_radix2_butterfly_pipe;

   localparam int W = 8;

   typedef struct {
      int a_re; int a_im; int b_re; int b_im; int w_re; int w_im;
      bit inv;  bit sc;
      int x0_re; int x0_im; int x1_re; int x1_im;
      bit sat;
   } vec_t;

   logic                Clock = 1'b0;
   logic                nReset = 1'b1;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic signed [W-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0, w_re = '0, w_im = '0;
   logic                inverse = 1'b0;
   logic                scale = 1'b0;
   logic                out_valid;
   logic                out_ready = 1'b1;
   logic signed [W-1:0] x0_re, x0_im, x1_re, x1_im;
   logic                ovf;
   logic                clr_ovf = 1'b0;

   int   n_checks = 0;
   int   n_errors = 0;
   vec_t vecs [13];
   vec_t items [6];

   radix2_butterfly_pipe #(.W(W), .FRAC(7)) dut (
      .Clock     (Clock),
      .nReset    (nReset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_re      (a_re),
      .a_im      (a_im),
      .b_re      (b_re),
      .b_im      (b_im),
      .w_re      (w_re),
      .w_im      (w_im),
      .inverse   (inverse),
      .scale     (scale),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .x0_re     (x0_re),
      .x0_im     (x0_im),
      .x1_re     (x1_re),
      .x1_im     (x1_im),
      .ovf       (ovf),
      .clr_ovf   (clr_ovf)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic drive_vec(input vec_t v);
      a_re    = W'(v.a_re);
      a_im    = W'(v.a_im);
      b_re    = W'(v.b_re);
      b_im    = W'(v.b_im);
      w_re    = W'(v.w_re);
      w_im    = W'(v.w_im);
      inverse = v.inv;
      scale   = v.sc;
   endtask

   task automatic check_out(input string tag, input vec_t v);
      check({tag, " x0_re"}, int'(x0_re), v.x0_re);
      check({tag, " x0_im"}, int'(x0_im), v.x0_im);
      check({tag, " x1_re"}, int'(x1_re), v.x1_re);
      check({tag, " x1_im"}, int'(x1_im), v.x1_im);
   endtask

   // Called at a negedge with an idle pipe; returns at the negedge where out_valid is first seen.
   task automatic send_item(input vec_t v, input string tag);
      int lat;
      drive_vec(v);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1 check({tag, " in_ready"}, int'(in_ready), 1);
      @(negedge Clock);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(negedge Clock);
         lat++;
      end
      check({tag, " latency"}, lat, 3);
      check_out(tag, v);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("vec%0d", idx);
      @(negedge Clock);
      send_item(v, tag);
      @(negedge Clock);
      check({tag, " ovf"}, int'(ovf), int'(v.sat));
      check({tag, " drained"}, int'(out_valid), 0);
      clr_ovf = 1'b1;
      @(negedge Clock);
      clr_ovf = 1'b0;
      check({tag, " ovf cleared"}, int'(ovf), 0);
   endtask

   initial begin
      //           a_re a_im b_re b_im w_re w_im inv sc  x0_re x0_im x1_re x1_im sat
      vecs[0]  = '{  10,  20,  30, -40, 127,    0, 0, 0,   40,  -20,  -20,   60, 0};
      vecs[1]  = '{  10,  20,  30, -40,   0, -128, 0, 0,  -30,  -10,   50,   50, 0};
      vecs[2]  = '{  10,  20,  30, -40,   0,  127, 1, 0,  -30,  -10,   50,   50, 0};
      vecs[3]  = '{  10,  20,  30, -40,   0, -127, 0, 0,  -30,  -10,   50,   50, 0};
      vecs[4]  = '{ 127, 127, 127,   0, 127,    0, 0, 0,  127,  127,    1,  127, 1};
      vecs[5]  = '{ 127, 127, 127,   0, 127,    0, 0, 1,  126,   63,    0,   63, 0};
      vecs[6]  = '{-128,-128, 127,   0, 127,    0, 0, 0,   -2, -128, -128, -128, 1};
      vecs[7]  = '{   0,   0,-128,   0,-128,    0, 0, 0,  127,    0, -128,    0, 1};
      vecs[8]  = '{   5,  -7, -20,  15,  90,  -90, 0, 0,    1,   18,    9,  -32, 0};
      vecs[9]  = '{   5,  -7, -20,  15,  90,  -90, 1, 0,  -20,  -11,   30,   -3, 0};
      vecs[10] = '{ -10,  -1,   0,   0,   0,    0, 0, 1,   -5,   -1,   -5,   -1, 0};
      vecs[11] = '{-128,-128,-128,   0,-128,    0, 0, 1,    0,  -64, -128,  -64, 0};
      vecs[12] = '{   0,   0,   0,-128,   0, -128, 1, 0,  127,    0, -128,    0, 1};
      items[0] = vecs[0];
      items[1] = vecs[8];
      items[2] = vecs[9];
      items[3] = vecs[5];
      items[4] = vecs[10];
      items[5] = vecs[11];

      // Power-on reset
      #3 nReset = 1'b0;
      #1;
      check("por out_valid", int'(out_valid), 0);
      check("por ovf", int'(ovf), 0);
      check("por x0_re", int'(x0_re), 0);
      check("por x1_im", int'(x1_im), 0);
      repeat (2) @(negedge Clock);
      nReset = 1'b1;
      #1 check("por in_ready", int'(in_ready), 1);

      // Table of single items
      for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

      // Sticky overflow, scaled retry, then clear
      @(negedge Clock);
      send_item(vecs[4], "sticky");
      repeat (5) @(negedge Clock);
      check("sticky ovf held", int'(ovf), 1);
      send_item(vecs[5], "sticky scaled");
      @(negedge Clock);
      check("sticky ovf after scaled", int'(ovf), 1);
      clr_ovf = 1'b1;
      @(negedge Clock);
      clr_ovf = 1'b0;
      check("sticky ovf cleared", int'(ovf), 0);

      // Clear held high while a saturating item lands: set must win
      @(negedge Clock);
      clr_ovf = 1'b1;
      send_item(vecs[4], "setwins");
      check("setwins ovf", int'(ovf), 1);
      clr_ovf = 1'b0;
      @(negedge Clock);
      check("setwins ovf held", int'(ovf), 1);
      clr_ovf = 1'b1;
      @(negedge Clock);
      clr_ovf = 1'b0;
      check("setwins ovf cleared", int'(ovf), 0);

      // Back-to-back stream with a 4-cycle output stall
      begin
         int tx = 0, rx = 0, stall_cnt = 0;
         bit stalled_prev = 0;
         logic signed [W-1:0] s0r = '0, s0i = '0, s1r = '0, s1i = '0;
         for (int c = 0; c < 40 && rx < 6; c++) begin
            @(negedge Clock);
            out_ready = !(c >= 3 && c < 7);
            if (stalled_prev) begin
               check("stall out_valid", int'(out_valid), 1);
               check("stall x0_re stable", int'(x0_re), int'(s0r));
               check("stall x0_im stable", int'(x0_im), int'(s0i));
               check("stall x1_re stable", int'(x1_re), int'(s1r));
               check("stall x1_im stable", int'(x1_im), int'(s1i));
            end
            if (out_valid && out_ready && rx < 6) begin
               check_out($sformatf("stream%0d", rx), items[rx]);
               rx++;
            end
            if (out_valid && !out_ready) begin
               s0r = x0_re; s0i = x0_im; s1r = x1_re; s1i = x1_im;
               stall_cnt++;
            end
            stalled_prev = out_valid && !out_ready;
            if (tx < 6) begin
               drive_vec(items[tx]);
               in_valid = 1'b1;
            end else begin
               in_valid = 1'b0;
            end
            #1;
            if (out_valid && !out_ready) check("stall in_ready", int'(in_ready), 0);
            if (in_valid && in_ready) tx++;
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
         check("stream sent", tx, 6);
         check("stream received", rx, 6);
         check("stream stall cycles", stall_cnt, 4);
         @(negedge Clock);
         check("stream ovf", int'(ovf), 0);
      end

      // Reset with three items in flight
      @(negedge Clock);
      drive_vec(vecs[4]);
      in_valid = 1'b1;
      repeat (3) @(negedge Clock);
      in_valid = 1'b0;
      check("pre-reset out_valid", int'(out_valid), 1);
      check("pre-reset ovf", int'(ovf), 1);
      nReset = 1'b0;
      #1;
      check("reset out_valid", int'(out_valid), 0);
      check("reset ovf", int'(ovf), 0);
      check("reset x0_re", int'(x0_re), 0);
      check("reset x0_im", int'(x0_im), 0);
      check("reset x1_re", int'(x1_re), 0);
      check("reset x1_im", int'(x1_im), 0);
      @(negedge Clock);
      nReset = 1'b1;
      send_item(vecs[0], "post-reset");
      @(negedge Clock);
      check("post-reset ovf", int'(ovf), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/radix2_butterfly_pipe.md
RADIX2_BUTTERFLY_PIPE -- requirements
Module: radix2_butterfly_pipe

Interface
REQ-001 Parameter W, default 8: signed two's-complement width of every data and twiddle component.
REQ-002 Parameter FRAC, default W-1: fractional bits of the twiddle (Q1.FRAC format).
REQ-003 One clock and one reset: reset is asynchronous and active-low, ports Clock and nReset.
REQ-004 Clock  input  1  rising-edge clock for all state.
REQ-005 nReset  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operand set present; in_ready  output  1  block accepts this cycle.
REQ-007 a_re, a_im, b_re, b_im  input  W each  complex operands A and B.
REQ-008 w_re, w_im  input  W each  complex twiddle.
REQ-009 inverse  input  1  sampled with operands; 1 selects conjugate twiddle (IFFT).
REQ-010 scale  input  1  sampled with operands; 1 divides both results by 2.
REQ-011 out_valid  output  1; out_ready  input  1  downstream handshake.
REQ-012 x0_re, x0_im, x1_re, x1_im  output  W each  results X0 = A+W*B, X1 = A-W*B.
REQ-013 ovf  output  1  sticky saturation flag; clr_ovf  input  1  synchronous clear.

Function
REQ-014 Transfer in occurs when in_valid and in_ready are both 1; transfer out occurs when out_valid and out_ready are both 1.
REQ-015 Pipeline has 3 stages; latency is exactly 3 cycles from input transfer to out_valid when there is no back-pressure; throughput is 1 per cycle.
REQ-016 Stage 1 registers the four 2W+1-bit products; the twiddle imaginary part is negated when inverse=1, held in W+1 bits so that negating -2^(W-1) is exact.
REQ-017 Stage 2 forms wb_re = br*wr - bi*wi and wb_im = br*wi + bi*wr, adds 2^(FRAC-1), arithmetic-shifts right by FRAC, and keeps W+2 bits.
REQ-018 Stage 3 forms a +/- wb in W+2 bits, arithmetic-shifts right by 1 (floor) when scale=1, then saturates each component to [-2^(W-1), 2^(W-1)-1].
REQ-019 Global advance enable = !out_valid || out_ready; all stages, together with their valid bits and the per-item inverse/scale flags, shift only when enabled.
REQ-020 in_ready equals the global advance enable (combinational); no item is dropped or duplicated under any back-pressure pattern.
REQ-021 While out_valid=1 and out_ready=0, the outputs hold stable.
REQ-022 ovf is set in the cycle an item leaves stage 3 with any component saturated; it stays set until reset or clr_ovf.
REQ-023 When clr_ovf and a new saturation occur in the same cycle, ovf ends up 1 (set wins).
REQ-024 Bubbles (in_valid=0) propagate as valid=0 and never set ovf.

Reset
REQ-025 nReset low clears all valid bits, out_valid=0, ovf=0, and all result outputs to 0, immediately and regardless of Clock.
REQ-026 Reset mid-operation discards all in-flight items; in_ready=1 in the first cycle after release.
REQ-027 Datapath product registers need no reset; only valid bits, output registers and ovf are reset.

Structure
REQ-028 Package bfly_pkg holds the default W/FRAC constants and the round-shift and saturate helper functions, shared with the future FFT stage controller.
REQ-029 Sub-module bfly_cmul (stages 1-2: complex multiply, conjugate, round) is instantiated once; add/sub/scale/saturate stays in radix2_butterfly_pipe.

Verification (W=8, FRAC=7)
REQ-030 A=(10,20), B=(30,-40), W=(127,0), inverse=0, scale=0 -> 3 cycles later X0=(40,-20), X1=(-20,60), ovf=0.
REQ-031 Same A and B, W=(0,-128) -> X0=(-30,-10), X1=(50,50); then W=(0,127), inverse=1 gives the same result as W=(0,-127), inverse=0.
REQ-032 A=(127,127), B=(127,0), W=(127,0), scale=0 -> X0_re=127 (saturated), ovf=1 and stays 1; same stimulus with scale=1 -> X0_re=126 and no new saturation; clr_ovf pulse -> ovf=0.
REQ-033 Stream 6 back-to-back items with out_ready held low from cycle 3 for 4 cycles -> in_ready=0 while stalled, outputs stable, all 6 results emerge in order with no loss.
REQ-034 Assert nReset for 1 cycle with 3 items in flight -> out_valid=0 and outputs 0 immediately; the next accepted item emerges 3 cycles after acceptance.
